// File: rtl/riscv_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_lsu: stallable load/store unit with byte lanes, load extension and  |
// | misaligned trap/split handling.                        rev 1.0            |
// +--------------------------------------------------------------------------+
module riscv_lsu #(
  parameter int XLEN          = 32,
  parameter int ADDR_W        = 32,
  parameter int MISALIGN_TRAP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [2:0]           req_size,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 busy,
  output logic                 rsp_valid,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 fault,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [XLEN/8-1:0]    mem_be,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [2:0]          size_q, size_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic                split_q, split_d;
  logic [ADDR_W-1:0]   addr1_q, addr1_d;
  logic [BE_W-1:0]     be1_q, be1_d;
  logic [XLEN-1:0]     wdata1_q, wdata1_d;
  logic [XLEN-1:0]     rlo_q, rlo_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;

  function automatic logic [BE_W-1:0] size_mask(input logic [1:0] sz);
    logic [BE_W-1:0] m;
    for (int i = 0; i < BE_W; i++) m[i] = (i < (1 << sz));
    return m;
  endfunction

  logic                misaligned, illegal, accept;
  logic [OFF_W-1:0]    off;
  logic [ADDR_W-1:0]   addr_al;
  logic [2*BE_W-1:0]   be_full;
  logic [2*XLEN-1:0]   wd_full;
  logic [2*XLEN-1:0]   rd_full;
  logic [XLEN-1:0]     ld_val, ld_bits, ld_result;
  logic [BE_W-1:0]     ld_mask;
  logic                ld_sign;

  always_comb begin
    unique case (req_size[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
    illegal = (req_size == 3'b111) ||
              ((XLEN == 32) && (req_size == 3'b011 || req_size == 3'b110)) ||
              ((MISALIGN_TRAP != 0) && misaligned);
    accept  = (state_q == IDLE) && req_valid && !illegal;

    off     = req_addr[OFF_W-1:0];
    addr_al = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    be_full = {{BE_W{1'b0}}, size_mask(req_size[1:0])} << off;
    wd_full = {{XLEN{1'b0}}, req_wdata} << {off, 3'b000};
  end

  // A split load merges the second (higher-address) word above the first.
  always_comb begin
    rd_full = (state_q == WAIT1) ? {mem_rdata, rlo_q} : {{XLEN{1'b0}}, mem_rdata};
    ld_val  = XLEN'(rd_full >> {off_q, 3'b000});
    ld_mask = size_mask(size_q[1:0]);
    for (int i = 0; i < BE_W; i++) ld_bits[8*i +: 8] = {8{ld_mask[i]}};
    unique case (size_q[1:0])
      2'd0:    ld_sign = ld_val[7];
      2'd1:    ld_sign = ld_val[15];
      2'd2:    ld_sign = ld_val[31];
      default: ld_sign = ld_val[XLEN-1];
    endcase
    ld_result = (ld_val & ld_bits) | ({XLEN{ld_sign & ~size_q[2]}} & ~ld_bits);
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    off_d       = off_q;
    split_d     = split_q;
    addr1_d     = addr1_q;
    be1_d       = be1_q;
    wdata1_d    = wdata1_q;
    rlo_d       = rlo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = REQ0;
          write_d     = req_write;
          size_d      = req_size;
          off_d       = off;
          split_d     = |be_full[2*BE_W-1:BE_W];
          addr1_d     = addr_al + ADDR_W'(BE_W);
          be1_d       = be_full[2*BE_W-1:BE_W];
          wdata1_d    = wd_full[2*XLEN-1:XLEN];
          mem_req_d   = 1'b1;
          mem_we_d    = req_write;
          mem_addr_d  = addr_al;
          mem_be_d    = be_full[BE_W-1:0];
          mem_wdata_d = wd_full[XLEN-1:0];
        end
      end
      REQ0, REQ1: begin
        if (mem_gnt) begin
          if (write_q && state_q == REQ0 && split_q) begin
            state_d     = REQ1;
            mem_addr_d  = addr1_q;
            mem_be_d    = be1_q;
            mem_wdata_d = wdata1_q;
          end else if (write_q) begin
            state_d     = DONE;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            rsp_valid_d = 1'b1;
          end else begin
            state_d   = (state_q == REQ0) ? WAIT0 : WAIT1;
            mem_req_d = 1'b0;
          end
        end
      end
      WAIT0, WAIT1: begin
        if (mem_rvalid) begin
          if (state_q == WAIT0 && split_q) begin
            state_d     = REQ1;
            rlo_d       = mem_rdata;
            mem_req_d   = 1'b1;
            mem_addr_d  = addr1_q;
            mem_be_d    = be1_q;
            mem_wdata_d = wdata1_q;
          end else begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = ld_result;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= 3'b000;
      off_q       <= '0;
      split_q     <= 1'b0;
      addr1_q     <= '0;
      be1_q       <= '0;
      wdata1_q    <= '0;
      rlo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      off_q       <= off_d;
      split_q     <= split_d;
      addr1_q     <= addr1_d;
      be1_q       <= be1_d;
      wdata1_q    <= wdata1_d;
      rlo_q       <= rlo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Stall/fault are qualified by reset so every output drops while it is held.
  assign busy      = reset && (accept || (state_q != IDLE && state_q != DONE));
  assign fault     = reset && (state_q == IDLE) && req_valid && illegal;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_riscv_lsu: directed bench for riscv_lsu (trap and split instances).    |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        req_valid, req_write, mem_gnt, mem_rvalid;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic        busy, rsp_valid, fault, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        s_req_valid, s_req_write, s_mem_gnt, s_mem_rvalid;
  logic [2:0]  s_req_size;
  logic [31:0] s_req_addr, s_req_wdata, s_mem_rdata;
  logic        s_busy, s_rsp_valid, s_fault, s_mem_req, s_mem_we;
  logic [31:0] s_rsp_rdata, s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_be;

  int checks = 0;
  int errors = 0;

  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  riscv_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGN_TRAP(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  riscv_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGN_TRAP(0)) u_spl (
    .clk(clk), .reset(reset),
    .req_valid(s_req_valid), .req_write(s_req_write), .req_size(s_req_size),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .busy(s_busy), .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .fault(s_fault),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_be(s_mem_be),
    .mem_wdata(s_mem_wdata), .mem_gnt(s_mem_gnt), .mem_rvalid(s_mem_rvalid), .mem_rdata(s_mem_rdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait transaction on the trap instance; returns in the DONE cycle.
  task automatic run_single(input logic wr, input logic [2:0] sz,
                            input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = ad; req_wdata = wd;
    cyc();
    cap_we = mem_we; cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata;
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    if (!wr) begin
      mem_rvalid = 1'b1; mem_rdata = rd;
      cyc();
      mem_rvalid = 1'b0;
    end
  endtask

  task automatic end_txn();
    req_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 0; req_write = 0; req_size = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    s_req_valid = 0; s_req_write = 0; s_req_size = 0; s_req_addr = 0; s_req_wdata = 0;
    s_mem_gnt = 0; s_mem_rvalid = 0; s_mem_rdata = 0;
    cyc(); cyc();
    checks++; if ({busy, rsp_valid, fault, mem_req, mem_we} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, rsp_valid, fault, mem_req, mem_we}); end
    checks++; if ({mem_be, mem_addr, mem_wdata, rsp_rdata} !== 100'b0) begin errors++;
      $display("FAIL reset_data: be %h addr %h wdata %h rdata %h expected all 0", mem_be, mem_addr, mem_wdata, rsp_rdata); end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_store_sw();
    req_valid = 1; req_write = 1; req_size = 3'b010; req_addr = 32'h100; req_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy_comb: got %b expected 1", busy); end
    cyc();
    checks++; if ({mem_req, mem_we, mem_be} !== 6'b111111) begin errors++;
      $display("FAIL sw_ctrl: req/we/be got %b expected 111111", {mem_req, mem_we, mem_be}); end
    checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL sw_bus: addr %h wdata %h expected 00000100 deadbeef", mem_addr, mem_wdata); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (mem_req !== 1'b1 || busy !== 1'b1 || rsp_valid !== 1'b0 || mem_addr !== 32'h100) begin errors++;
        $display("FAIL sw_hold%0d: req %b busy %b rsp %b addr %h expected 1 1 0 00000100", i, mem_req, busy, rsp_valid, mem_addr); end
    end
    mem_gnt = 1;
    cyc();
    mem_gnt = 0;
    checks++; if (rsp_valid !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL sw_done: rsp %b busy %b req %b expected 1 0 0", rsp_valid, busy, mem_req); end
    end_txn();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sw_pulse: rsp_valid got %b expected 0", rsp_valid); end
  endtask

  task automatic test_loads();
    run_single(0, 3'b000, 32'h103, 32'h0, 32'h80FFFF00);
    checks++; if (cap_be !== 4'b1000 || cap_addr !== 32'h100 || cap_we !== 1'b0) begin errors++;
      $display("FAIL lb_bus: be %b addr %h we %b expected 1000 00000100 0", cap_be, cap_addr, cap_we); end
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFFFF80) begin errors++;
      $display("FAIL lb_data: valid %b rdata %h expected 1 ffffff80", rsp_valid, rsp_rdata); end
    end_txn();
    run_single(0, 3'b100, 32'h103, 32'h0, 32'h80FFFF00);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00000080) begin errors++;
      $display("FAIL lbu_data: valid %b rdata %h expected 1 00000080", rsp_valid, rsp_rdata); end
    end_txn();
    run_single(0, 3'b001, 32'h102, 32'h0, 32'h80FFFF00);
    checks++; if (cap_be !== 4'b1100 || rsp_rdata !== 32'hFFFF80FF) begin errors++;
      $display("FAIL lh_data: be %b rdata %h expected 1100 ffff80ff", cap_be, rsp_rdata); end
    end_txn();
    run_single(0, 3'b101, 32'h100, 32'h0, 32'h1234F00D);
    checks++; if (cap_be !== 4'b0011 || rsp_rdata !== 32'h0000F00D) begin errors++;
      $display("FAIL lhu_data: be %b rdata %h expected 0011 0000f00d", cap_be, rsp_rdata); end
    end_txn();
    run_single(0, 3'b010, 32'h104, 32'h0, 32'h87654321);
    checks++; if (cap_addr !== 32'h104 || rsp_rdata !== 32'h87654321) begin errors++;
      $display("FAIL lw_data: addr %h rdata %h expected 00000104 87654321", cap_addr, rsp_rdata); end
    end_txn();
  endtask

  task automatic test_store_sh();
    run_single(1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0);
    checks++; if (cap_be !== 4'b1100 || cap_wdata !== 32'hABCD0000 || cap_we !== 1'b1) begin errors++;
      $display("FAIL sh_bus: be %b wdata %h we %b expected 1100 abcd0000 1", cap_be, cap_wdata, cap_we); end
    checks++; if (rsp_valid !== 1'b1 || mem_req !== 1'b0) begin errors++;
      $display("FAIL sh_single_beat: rsp %b req %b expected 1 0", rsp_valid, mem_req); end
    end_txn();
    run_single(1, 3'b000, 32'h201, 32'h000000A5, 32'h0);
    checks++; if (cap_be !== 4'b0010 || cap_wdata !== 32'h0000A500 || cap_addr !== 32'h200) begin errors++;
      $display("FAIL sb_bus: be %b wdata %h addr %h expected 0010 0000a500 00000200", cap_be, cap_wdata, cap_addr); end
    end_txn();
  endtask

  task automatic test_misalign_trap();
    req_valid = 1; req_write = 0; req_size = 3'b010; req_addr = 32'h101;
    #1;
    checks++; if (fault !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL trap_lw: fault %b busy %b expected 1 0", fault, busy); end
    cyc();
    checks++; if (mem_req !== 1'b0 || fault !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL trap_idle: req %b fault %b rsp %b expected 0 1 0", mem_req, fault, rsp_valid); end
    req_size = 3'b011; req_addr = 32'h100;
    #1;
    checks++; if (fault !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL trap_size_d: fault %b busy %b expected 1 0", fault, busy); end
    req_size = 3'b111;
    #1;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL trap_size_7: fault %b expected 1", fault); end
    req_write = 1; req_size = 3'b001; req_addr = 32'h103;
    #1;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL trap_sh: fault %b expected 1", fault); end
    req_valid = 0;
    #1;
    checks++; if (fault !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL trap_clear: fault %b req %b expected 0 0", fault, mem_req); end
    cyc();
  endtask

  task automatic test_split();
    s_req_valid = 1; s_req_write = 0; s_req_size = 3'b010; s_req_addr = 32'h0FE;
    #1;
    checks++; if (s_fault !== 1'b0 || s_busy !== 1'b1) begin errors++;
      $display("FAIL split_accept: fault %b busy %b expected 0 1", s_fault, s_busy); end
    cyc();
    checks++; if (s_mem_addr !== 32'h0FC || s_mem_be !== 4'b1100 || s_mem_req !== 1'b1) begin errors++;
      $display("FAIL split_beat0: addr %h be %b req %b expected 000000fc 1100 1", s_mem_addr, s_mem_be, s_mem_req); end
    s_mem_gnt = 1; cyc(); s_mem_gnt = 0;
    s_mem_rvalid = 1; s_mem_rdata = 32'h44332211; cyc(); s_mem_rvalid = 0;
    checks++; if (s_mem_addr !== 32'h100 || s_mem_be !== 4'b0011 || s_mem_req !== 1'b1) begin errors++;
      $display("FAIL split_beat1: addr %h be %b req %b expected 00000100 0011 1", s_mem_addr, s_mem_be, s_mem_req); end
    s_mem_gnt = 1; cyc(); s_mem_gnt = 0;
    checks++; if (s_rsp_valid !== 1'b0 || s_busy !== 1'b1) begin errors++;
      $display("FAIL split_wait1: rsp %b busy %b expected 0 1", s_rsp_valid, s_busy); end
    s_mem_rvalid = 1; s_mem_rdata = 32'h88776655; cyc(); s_mem_rvalid = 0;
    checks++; if (s_rsp_valid !== 1'b1 || s_rsp_rdata !== 32'h66554433) begin errors++;
      $display("FAIL split_lw: valid %b rdata %h expected 1 66554433", s_rsp_valid, s_rsp_rdata); end
    s_req_valid = 0; cyc();

    s_req_valid = 1; s_req_write = 1; s_req_size = 3'b010; s_req_addr = 32'h0FE; s_req_wdata = 32'hAABBCCDD;
    cyc();
    checks++; if (s_mem_be !== 4'b1100 || s_mem_wdata !== 32'hCCDD0000 || s_mem_we !== 1'b1) begin errors++;
      $display("FAIL split_sw0: be %b wdata %h we %b expected 1100 ccdd0000 1", s_mem_be, s_mem_wdata, s_mem_we); end
    s_mem_gnt = 1; cyc(); s_mem_gnt = 0;
    checks++; if (s_mem_be !== 4'b0011 || s_mem_wdata !== 32'h0000AABB || s_mem_addr !== 32'h100 || s_rsp_valid !== 1'b0) begin errors++;
      $display("FAIL split_sw1: be %b wdata %h addr %h rsp %b expected 0011 0000aabb 00000100 0", s_mem_be, s_mem_wdata, s_mem_addr, s_rsp_valid); end
    s_mem_gnt = 1; cyc(); s_mem_gnt = 0;
    checks++; if (s_rsp_valid !== 1'b1 || s_mem_req !== 1'b0) begin errors++;
      $display("FAIL split_sw_done: rsp %b req %b expected 1 0", s_rsp_valid, s_mem_req); end
    s_req_valid = 0; cyc();
  endtask

  task automatic test_reset_mid();
    req_valid = 1; req_write = 0; req_size = 3'b010; req_addr = 32'h100;
    cyc();
    mem_gnt = 1; cyc(); mem_gnt = 0;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL mid_wait0: req %b busy %b expected 0 1", mem_req, busy); end
    reset = 1'b0;
    #1;
    checks++; if ({busy, rsp_valid, fault, mem_req, mem_we, mem_be} !== 9'b0 || mem_addr !== 32'h0) begin errors++;
      $display("FAIL mid_reset: busy %b rsp %b fault %b req %b we %b be %b addr %h expected all 0",
               busy, rsp_valid, fault, mem_req, mem_we, mem_be, mem_addr); end
    req_valid = 0;
    cyc();
    reset = 1'b1;
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    cyc();
    mem_rvalid = 0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL mid_stale_rvalid: rsp %b busy %b expected 0 0", rsp_valid, busy); end
    cyc();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: rsp_valid %b expected 0", rsp_valid); end
    run_single(1, 3'b010, 32'h200, 32'h0BADF00D, 32'h0);
    checks++; if (cap_addr !== 32'h200 || cap_wdata !== 32'h0BADF00D || cap_be !== 4'b1111 || rsp_valid !== 1'b1) begin errors++;
      $display("FAIL mid_next_sw: addr %h wdata %h be %b rsp %b expected 00000200 0badf00d 1111 1", cap_addr, cap_wdata, cap_be, rsp_valid); end
    end_txn();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_sw();
    test_loads();
    test_store_sh();
    test_misalign_trap();
    test_split();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Parametrised load/store unit for the next-generation pipelined RISC-V core.
- Replaces the single-cycle memwrite/memsize/aluout/writedata/readdata memory path with a stallable, handshaked data-memory port.
- Sits between the M stage and data memory. Adds byte enables, lane alignment, load sign/zero extension, variable memory latency, and misaligned-access trap or split handling.
- XLEN is 32 or 64.

Parameters:
- XLEN, 32: data width, 32 or 64. BE_W = XLEN/8, OFF_W = log2(BE_W).
- ADDR_W, 32: address width.
- MISALIGN_TRAP, 1: 1 = misaligned access raises fault; 0 = misaligned access is split into two bus beats.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  M-stage access request; held stable while busy=1
- req_write  in  1  1 = store, 0 = load
- req_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, LSB-justified
- busy  out  1  pipeline stall
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  XLEN  extended load result, valid with rsp_valid
- fault  out  1  misaligned or illegal-size request, no access made
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  word-aligned address (low OFF_W bits zero)
- mem_be  out  BE_W  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; earliest in the cycle after mem_gnt
- mem_rdata  in  XLEN  read word

Behaviour:
- Reset (reset=0), asynchronous: state IDLE. busy, rsp_valid, fault, mem_req, mem_we = 0. mem_be, mem_addr, mem_wdata, rsp_rdata = 0.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE, with req_valid=1 and a legal, allowed request:
  - Capture request; busy=1 combinationally.
  - Go to REQ0.
  - req_valid=0: stay in IDLE.
- Illegal request, checked in IDLE:
  - Illegal: size 011/110 when XLEN=32, size 111, or misaligned with MISALIGN_TRAP=1.
  - fault=1 combinationally, busy=0, no bus activity, stay in IDLE.
  - The pipeline owns the trap.
- Aligned means addr mod access-bytes = 0.
- REQ0/REQ1:
  - mem_req=1; address, be and wdata are driven from registers and held until mem_gnt.
  - Store + gnt: go to REQ1 if a second beat is pending, else DONE.
  - Load + gnt: go to WAIT0/WAIT1.
- WAIT0/WAIT1:
  - mem_req=0.
  - On mem_rvalid, capture shifted bytes, then go to REQ1 (split pending) or DONE.
- DONE:
  - rsp_valid=1 and busy=0 for exactly one cycle; the pipeline advances on this edge.
  - req_valid is ignored in DONE; always returns to IDLE.
- Latency, zero wait states: store rsp_valid 2 cycles after acceptance, load 3. A split load takes 5.
- Lane mapping:
  - mem_be = size mask << addr[OFF_W-1:0].
  - mem_wdata = req_wdata << 8*offset.
  - Load: word >> 8*offset, then sign extend (B/H/W) or zero extend (BU/HU/WU) to XLEN. D needs no extension.
- Split (MISALIGN_TRAP=0), applies when offset + bytes > BE_W:
  - Beat0: aligned addr, upper lanes.
  - Beat1: addr + BE_W, low lanes.
  - Load bytes are merged low-beat-first before extension.
- mem_gnt and mem_rvalid are ignored outside REQx/WAITx. An rvalid arriving after reset is discarded.
- Reset mid-access aborts the transaction; no rsp_valid.

Test Plan (XLEN=32):
- SW 0x100, wdata 0xDEADBEEF, gnt after 2 wait cycles -> mem_addr 0x100, mem_be 1111, mem_wdata 0xDEADBEEF, mem_we=1; rsp_valid the cycle after gnt; busy high until DONE.
- LB 0x103, mem_rdata 0x80FFFF00 -> mem_be 1000, rsp_rdata 0xFFFFFF80. LBU same address -> 0x00000080.
- SH 0x102, wdata 0x1234ABCD -> mem_be 1100, mem_wdata 0xABCD0000, single beat.
- MISALIGN_TRAP=1, LW 0x101 -> fault=1, busy=0, mem_req stays 0, FSM stays IDLE. Size 011 -> fault=1.
- MISALIGN_TRAP=0, LW 0x0FE:
  - Beat0: addr 0x0FC, be 1100, rdata 0x44332211.
  - Beat1: addr 0x100, be 0011, rdata 0x88776655.
  - Result: rsp_rdata 0x66554433 in cycle 5.
- Reset low during WAIT0 -> all outputs 0 immediately. mem_rvalid asserted after release -> no rsp_valid. Next SW completes normally.
